monitor_descarga: RTL and testbench

Parametrised battery-discharge monitor and the successor to the combinational low-battery LED identifier. It classifies a sampled battery level into NORMAL, BAJO (low) or CRITICO (critical). Hysteresis and a consecutive-sample filter prevent chatter near the thresholds. It drives a status LED that is off, steady on, or blinking. It sits between the battery-level source (ADC or switches) and the board LED.

---
 rtl/monitor_descarga.sv | 135 +++++++++++++
 tb/tb_monitor_descarga.sv | 116 +++++++++++
 2 files changed

// File: rtl/monitor_descarga.sv
// rtl/monitor_descarga.sv - battery discharge monitor with hysteresis, sample filter and status LED
// Classifies a sampled battery level into NORMAL/BAJO/CRITICO and drives a steady or blinking LED.
module monitor_descarga #(
  parameter int WIDTH     = 4,
  parameter int LOW_TH    = 4,
  parameter int CRIT_TH   = 2,
  parameter int HYST      = 1,
  parameter int FILT      = 3,
  parameter int BLINK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] nivel,
  input  logic             nivel_valid,
  output logic [1:0]       estado,
  output logic             bajo,
  output logic             critico,
  output logic             led
);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    BAJO    = 2'b01,
    CRITICO = 2'b10
  } state_e;

  localparam int CW = $clog2(FILT + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Thresholds held in WIDTH+1 bits so the hysteresis sums cannot wrap.
  localparam logic [WIDTH:0] LOW_EXT   = (WIDTH+1)'(LOW_TH);
  localparam logic [WIDTH:0] CRIT_EXT  = (WIDTH+1)'(CRIT_TH);
  localparam logic [WIDTH:0] LOW_HYST  = (WIDTH+1)'(LOW_TH + HYST);
  localparam logic [WIDTH:0] CRIT_HYST = (WIDTH+1)'(CRIT_TH + HYST);
  localparam logic [CW-1:0]  FILT_C    = CW'(FILT);
  localparam logic [BW-1:0]  BLINK_TOP = BW'(BLINK_DIV - 1);

  state_e          state_q, state_d;
  state_e          last_q, last_d;
  state_e          cand;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [BW-1:0]   blink_q, blink_d;
  logic            led_q, led_d;
  logic [WIDTH:0]  niv_ext;

  assign niv_ext = {1'b0, nivel};
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    cand = NORMAL;
    case (state_q)
      BAJO: begin
        if (niv_ext <= CRIT_EXT)      cand = CRITICO;
        else if (niv_ext > LOW_HYST)  cand = NORMAL;
        else                          cand = BAJO;
      end
      CRITICO: begin
        if (niv_ext > LOW_HYST)       cand = NORMAL;
        else if (niv_ext > CRIT_HYST) cand = BAJO;
        else                          cand = CRITICO;
      end
      default: begin
        if (niv_ext <= CRIT_EXT)      cand = CRITICO;
        else if (niv_ext <= LOW_EXT)  cand = BAJO;
        else                          cand = NORMAL;
      end
    endcase
  end

  // A differing candidate restarts the count at 1; it never completes an older run.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (nivel_valid) begin
      if (cand == state_q) begin
        cnt_d = '0;
      end else if (cand == last_q) begin
        if (cnt_inc == FILT_C) begin
          state_d = cand;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        last_d = cand;
        if (FILT_C == CW'(1)) begin
          state_d = cand;
          cnt_d   = '0;
        end else begin
          cnt_d = CW'(1);
        end
      end
    end
  end

  always_comb begin
    blink_d = '0;
    led_d   = 1'b0;
    if (state_d == CRITICO) begin
      if (state_q != CRITICO) begin
        led_d = 1'b1;
      end else if (blink_q == BLINK_TOP) begin
        led_d = ~led_q;
      end else begin
        blink_d = blink_q + 1'b1;
        led_d   = led_q;
      end
    end else begin
      led_d = (state_d == BAJO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      last_q  <= NORMAL;
      cnt_q   <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign estado  = state_q;
  assign bajo    = (state_q == BAJO);
  assign critico = (state_q == CRITICO);
  assign led     = led_q;

endmodule

// File: tb/tb_monitor_descarga.sv
// tb/tb_monitor_descarga.sv - table-driven bench for monitor_descarga at default parameters
module tb_monitor_descarga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] nivel = 4'd0;
  logic       nivel_valid = 1'b0;
  logic [1:0] estado;
  logic       bajo, critico, led;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       r;
    logic       v;
    logic [3:0] n;
    logic [1:0] e;
    logic       l;
  } vec_t;

  vec_t tbl[$];

  monitor_descarga dut (
    .clk(clk), .rst_n(rst_n), .nivel(nivel), .nivel_valid(nivel_valid),
    .estado(estado), .bajo(bajo), .critico(critico), .led(led)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic v, input logic [3:0] n, input logic [1:0] e, input logic l);
    vec_t t;
    t.r = r; t.v = v; t.n = n; t.e = e; t.l = l;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e, input logic l);
    chk({tag, " estado"}, int'(estado), int'(e));
    chk({tag, " bajo"}, int'(bajo), int'(e == 2'b01));
    chk({tag, " critico"}, int'(critico), int'(e == 2'b10));
    chk({tag, " led"}, int'(led), int'(l));
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] n);
    @(negedge clk);
    rst_n = r; nivel_valid = v; nivel = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then NORMAL hold
    add(0, 0, 0, 0, 0); add(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 1, 15, 0, 0);
    // filter length: two lows then recovery, then three lows
    add(1, 1, 3, 0, 0); add(1, 1, 3, 0, 0); add(1, 1, 15, 0, 0);
    add(1, 1, 3, 0, 0); add(1, 1, 3, 0, 0); add(1, 1, 3, 1, 1);
    // hysteresis: 5 holds BAJO, 6 recovers
    for (int i = 0; i < 10; i++) add(1, 1, 5, 1, 1);
    add(1, 1, 6, 1, 1); add(1, 1, 6, 1, 1); add(1, 1, 6, 0, 0);
    // direct jump to CRITICO and blink
    add(1, 1, 1, 0, 0); add(1, 1, 1, 0, 0); add(1, 1, 1, 2, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 2, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 2, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 2, 1);
    // recovery to BAJO: blinking continues until the third agreeing sample
    add(1, 1, 4, 2, 0); add(1, 1, 4, 2, 0); add(1, 1, 4, 1, 1);
    add(1, 1, 4, 1, 1); add(1, 1, 4, 1, 1);
    // back to NORMAL, then alternating candidates never complete
    add(1, 1, 15, 1, 1); add(1, 1, 15, 1, 1); add(1, 1, 15, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add(1, 1, 1, 0, 0); add(1, 1, 3, 0, 0);
    end
    // invalid gap holds the partial count
    add(1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 15, 0, 0);
    add(1, 1, 1, 0, 0); add(1, 1, 1, 2, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].e, tbl[i].l);
    end

    // reset mid-blink acts without a clock edge
    step(1, 1, 1);
    chk_all("pre_rst", 2'b10, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_all("async_rst", 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 2'b00, 1'b0);

    // after release three fresh samples are needed, and blink restarts high
    step(1, 1, 1); chk_all("post1", 2'b00, 1'b0);
    step(1, 1, 1); chk_all("post2", 2'b00, 1'b0);
    step(1, 1, 1); chk_all("post3", 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1); chk_all($sformatf("reblink%0d", i), 2'b10, 1'b1);
    end
    step(1, 1, 1); chk_all("reblink_low", 2'b10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
